// File: rtl/adc_scan_uart_tx_pkg.sv
// Shared encodings and helpers for the ADC scanner / serial-link block.
package adc_scan_pkg;

    // Ceiling log2, never less than 1 so single-value ranges still get a bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((64'd1 << width) < 64'(value)) width++;
        if (width == 0) width = 1;
        return width;
    endfunction

    // Scan FSM encodings; S_IDLE is only occupied while/just after reset.
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_MUX      = 3'd1;
    localparam logic [2:0] S_SOC      = 3'd2;
    localparam logic [2:0] S_EOC_HI   = 3'd3;
    localparam logic [2:0] S_EOC_LO   = 3'd4;
    localparam logic [2:0] S_LATCH    = 3'd5;
    localparam logic [2:0] S_TX       = 3'd6;

    // Serializer FSM encodings.
    localparam logic [2:0] T_IDLE     = 3'd0;
    localparam logic [2:0] T_WAIT_DSR = 3'd1;
    localparam logic [2:0] T_START    = 3'd2;
    localparam logic [2:0] T_DATA     = 3'd3;
    localparam logic [2:0] T_PAR      = 3'd4;
    localparam logic [2:0] T_STOP     = 3'd5;

    // Line levels for the fixed frame bits.
    localparam logic BIT_START = 1'b0;
    localparam logic BIT_STOP  = 1'b1;
    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/adc_scan_uart_tx_if.sv
// ADC front-end and serial-line signal bundle.
interface adc_scan_uart_tx_if #(
    parameter int unsigned CH_W   = 3,
    parameter int unsigned DATA_W = 8
);
    logic              eoc;
    logic [DATA_W-1:0] data_in;
    logic              dsr;
    logic              mux_en;
    logic              soc;
    logic              load_dato;
    logic [CH_W-1:0]   canale;
    logic              data_out;
    logic              tx_done;
    logic              error;
    logic              busy;

    // Block side.
    modport master (
        input  eoc, data_in, dsr,
        output mux_en, soc, load_dato, canale, data_out, tx_done, error, busy
    );

    // Environment side (ADC, remote end).
    modport slave (
        output eoc, data_in, dsr,
        input  mux_en, soc, load_dato, canale, data_out, tx_done, error, busy
    );
endinterface

// File: rtl/adc_scan_uart_tx_uart_frame_tx.sv
// One asynchronous frame: start, payload MSB first, optional even parity, stop.
module uart_frame_tx
    import adc_scan_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BIT_CYC   = 105,
    parameter int unsigned PARITY_EN = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,      // one-cycle request, only issued while idle
    input  logic              i_last,     // frame is the data frame of a transfer
    input  logic [DATA_W-1:0] i_payload,
    input  logic              i_dsr,
    output logic              o_line,
    output logic              o_done,     // after every frame
    output logic              o_tx_done,  // after data frames only
    output logic              o_stall,    // request met dsr low
    output logic              o_clr_err   // data frame entering START
);
    localparam int unsigned CNT_W = clog2(BIT_CYC);
    localparam int unsigned IDX_W = clog2(DATA_W);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [CNT_W-1:0]  r_cyc;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_next_idx;
    logic [DATA_W-1:0] r_payload;
    logic              r_last;
    logic              r_line;
    logic              r_done;
    logic              r_tx_done;
    logic              w_line_next;
    logic              w_cyc_end;
    logic              w_bit_state;
    logic              w_stall;
    logic              w_go;
    logic              w_frame_last;

    assign w_cyc_end    = (r_cyc == CNT_W'(BIT_CYC - 1));
    assign w_bit_state  = (r_state == T_START) || (r_state == T_DATA) ||
                          (r_state == T_PAR)   || (r_state == T_STOP);
    assign w_frame_last = (r_state == T_IDLE) ? i_last : r_last;

    // Next state, payload bit index, and the line level for the next cycle.
    always_comb begin
        w_next      = r_state;
        w_next_idx  = r_idx;
        w_stall     = 1'b0;
        w_line_next = LINE_IDLE;
        case (r_state)
            T_IDLE: begin
                if (i_req) begin
                    if (i_dsr) begin
                        w_next = T_START;
                    end else begin
                        w_next  = T_WAIT_DSR;
                        w_stall = 1'b1;
                    end
                end
            end
            T_WAIT_DSR: if (i_dsr) w_next = T_START;
            T_START: begin
                if (w_cyc_end) begin
                    w_next     = T_DATA;
                    w_next_idx = '0;
                end
            end
            T_DATA: begin
                if (w_cyc_end) begin
                    if (r_idx == IDX_W'(DATA_W - 1))
                        w_next = (PARITY_EN != 0) ? T_PAR : T_STOP;
                    else
                        w_next_idx = r_idx + 1'b1;
                end
            end
            T_PAR:   if (w_cyc_end) w_next = T_STOP;
            T_STOP:  if (w_cyc_end) w_next = T_IDLE;
            default: w_next = T_IDLE;
        endcase
        case (w_next)
            T_START: w_line_next = BIT_START;
            T_DATA:  w_line_next = r_payload[IDX_W'(DATA_W - 1) - w_next_idx];
            T_PAR:   w_line_next = ^r_payload;
            T_STOP:  w_line_next = BIT_STOP;
            default: w_line_next = LINE_IDLE;
        endcase
    end

    assign w_go = (w_next == T_START) && (r_state != T_START);

    // Frame state, bit timing and registered line/done outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= T_IDLE;
            r_cyc     <= '0;
            r_idx     <= '0;
            r_payload <= '0;
            r_last    <= 1'b0;
            r_line    <= LINE_IDLE;
            r_done    <= 1'b0;
            r_tx_done <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_idx     <= w_next_idx;
            r_cyc     <= (w_bit_state && !w_cyc_end) ? r_cyc + 1'b1 : '0;
            r_line    <= w_line_next;
            r_done    <= (r_state == T_STOP) && w_cyc_end;
            r_tx_done <= (r_state == T_STOP) && w_cyc_end && r_last;
            if ((r_state == T_IDLE) && i_req) begin
                r_payload <= i_payload;
                r_last    <= i_last;
            end
        end
    end

    assign o_line    = r_line;
    assign o_done    = r_done;
    assign o_tx_done = r_tx_done;
    assign o_stall   = w_stall;
    assign o_clr_err = w_go && w_frame_last;

endmodule

// File: rtl/adc_scan_uart_tx.sv
// Round-robin ADC scanner that ships each result over a DSR-gated serial line.
module adc_scan_uart_tx
    import adc_scan_pkg::*;
#(
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned BIT_CYC     = 105,
    parameter int unsigned PARITY_EN   = 0,
    parameter int unsigned TAG_EN      = 0,
    parameter int unsigned EOC_TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset,
    adc_scan_uart_tx_if.master bus
);
    localparam int unsigned CH_W = clog2(NUM_CH);
    localparam int unsigned TO_W = clog2(EOC_TIMEOUT + 1);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [TO_W-1:0]   r_to_cnt;
    logic [CH_W-1:0]   r_canale;
    logic [CH_W-1:0]   w_ch_next;
    logic [CH_W-1:0]   r_tag;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_payload;
    logic              r_req;
    logic              r_is_tag;
    logic              r_mux_en;
    logic              r_soc;
    logic              r_load;
    logic              r_busy;
    logic              r_error;
    logic              w_to_hit;
    logic              w_abort;
    logic              w_line;
    logic              w_done;
    logic              w_tx_done;
    logic              w_stall;
    logic              w_clr;

    assign w_to_hit  = (r_to_cnt == TO_W'(EOC_TIMEOUT - 1));
    assign w_ch_next = (r_canale == CH_W'(NUM_CH - 1)) ? '0 : r_canale + 1'b1;
    assign w_payload = r_is_tag ? DATA_W'(r_tag) : r_data;

    // Scan sequencing, including conversion-timeout abort.
    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        case (r_state)
            S_IDLE:   w_next = S_MUX;
            S_MUX:    w_next = S_SOC;
            S_SOC:    w_next = S_EOC_HI;
            S_EOC_HI: begin
                if (bus.eoc) begin
                    w_next = S_EOC_LO;
                end else if (w_to_hit) begin
                    w_next  = S_MUX;
                    w_abort = 1'b1;
                end
            end
            S_EOC_LO: begin
                if (!bus.eoc) begin
                    w_next = S_LATCH;
                end else if (w_to_hit) begin
                    w_next  = S_MUX;
                    w_abort = 1'b1;
                end
            end
            S_LATCH:  w_next = S_TX;
            S_TX:     if (w_done && !r_is_tag) w_next = S_MUX;
            default:  w_next = S_MUX;
        endcase
    end

    // State register; strobes decoded from the next state so they align with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_mux_en <= 1'b0;
            r_soc    <= 1'b0;
            r_load   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_mux_en <= (w_next == S_MUX) || (w_next == S_SOC) ||
                        (w_next == S_EOC_HI) || (w_next == S_EOC_LO);
            r_soc    <= (w_next == S_SOC) || (w_next == S_EOC_HI);
            r_load   <= (w_next == S_LATCH);
            r_busy   <= (w_next != S_IDLE) && (w_next != S_MUX);
        end
    end

    // Timeout counter, restarted on every entry into an eoc wait state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_to_cnt <= '0;
        else if (w_next != r_state)
            r_to_cnt <= '0;
        else if ((r_state == S_EOC_HI) || (r_state == S_EOC_LO))
            r_to_cnt <= r_to_cnt + 1'b1;
    end

    // Result capture and channel advance (on latch or abort).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_canale <= '0;
            r_tag    <= '0;
            r_data   <= '0;
        end else if (r_state == S_LATCH) begin
            r_data   <= bus.data_in;
            r_tag    <= r_canale;
            r_canale <= w_ch_next;
        end else if (w_abort) begin
            r_canale <= w_ch_next;
        end
    end

    // Frame requests: optional tag frame first, data frame after its done pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_req    <= 1'b0;
            r_is_tag <= 1'b0;
        end else if (r_state == S_LATCH) begin
            r_req    <= 1'b1;
            r_is_tag <= (TAG_EN != 0);
        end else if (w_done && r_is_tag) begin
            r_req    <= 1'b1;
            r_is_tag <= 1'b0;
        end else begin
            r_req    <= 1'b0;
        end
    end

    // Sticky error; a simultaneous set wins over the data-frame clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_error <= 1'b0;
        else if (w_abort || w_stall)
            r_error <= 1'b1;
        else if (w_clr)
            r_error <= 1'b0;
    end

    uart_frame_tx #(
        .DATA_W    (DATA_W),
        .BIT_CYC   (BIT_CYC),
        .PARITY_EN (PARITY_EN)
    ) u_frame (
        .i_clk     (clock),
        .i_rst     (reset),
        .i_req     (r_req),
        .i_last    (!r_is_tag),
        .i_payload (w_payload),
        .i_dsr     (bus.dsr),
        .o_line    (w_line),
        .o_done    (w_done),
        .o_tx_done (w_tx_done),
        .o_stall   (w_stall),
        .o_clr_err (w_clr)
    );

    assign bus.mux_en    = r_mux_en;
    assign bus.soc       = r_soc;
    assign bus.load_dato = r_load;
    assign bus.canale    = r_canale;
    assign bus.data_out  = w_line;
    assign bus.tx_done   = w_tx_done;
    assign bus.error     = r_error;
    assign bus.busy      = r_busy;

endmodule

// File: doc/adc_scan_uart_tx.md
Name: adc_scan_uart_tx

Overview:
Parametrised successor of the ITC99-style ADC scanner/serial-link block. It sequences an external multiplexed ADC round-robin over NUM_CH channels and latches each conversion result. It then ships each result as an asynchronous serial frame, with optional channel tag and parity, under DSR flow control. It sits between the analogue front-end interface and the board-level serial line, and owns the conversion timeout and link error reporting.

Parameters:
NUM_CH, 8, number of multiplexer channels scanned (2..16); CH_W = clog2(NUM_CH), minimum 1.
DATA_W, 8, ADC result width and data-frame payload width (4..16).
BIT_CYC, 105, clock cycles per serial bit (>=2); counter width = clog2(BIT_CYC).
PARITY_EN, 0, 1 = even-parity bit appended after payload.
TAG_EN, 0, 1 = channel-index frame (CH_W bits, zero-extended to DATA_W) sent before each data frame.
EOC_TIMEOUT, 255, max cycles waiting on any eoc edge before abort.

Ports:
clock  in  1  rising-edge system clock
reset  in  1  asynchronous, active-high reset
eoc  in  1  ADC end-of-conversion; high while converting
data_in  in  DATA_W  ADC result, valid when eoc low after conversion
dsr  in  1  remote ready; frame may start only when high
mux_en  out  1  analogue mux enable
soc  out  1  start of conversion
load_dato  out  1  one-cycle ADC output-latch strobe
canale  out  CH_W  channel currently selected
data_out  out  1  serial line, idle high
tx_done  out  1  one-cycle pulse after last stop bit of a data frame
error  out  1  sticky link/ADC error flag
busy  out  1  high whenever scan FSM not in S_MUX

Behaviour:
- Reset (async, any state, mid-frame included): canale=0; mux_en, soc, load_dato, tx_done, error, busy = 0; data_out=1; both FSMs idle; all counters 0. First S_MUX occurs on the first clock after reset deasserts.
- All outputs registered. The values stated per state hold during the cycles the state is occupied.
- Scan FSM: S_MUX -> S_SOC -> S_EOC_HI -> S_EOC_LO -> S_LATCH -> S_TX -> S_MUX.
  - S_MUX: 1 cycle, mux_en=1.
  - S_SOC: 1 cycle, mux_en=1, soc=1.
  - S_EOC_HI: soc=1; wait for eoc=1.
  - S_EOC_LO: soc=0; wait for eoc=0.
  - S_LATCH: 1 cycle, load_dato=1, mux_en=0; capture data_in; canale <= (canale==NUM_CH-1) ? 0 : canale+1.
  - S_TX: raise tx request; return to S_MUX on the cycle tx_done (or tag+data completion) is seen.
- Timeout: one cycle counter, cleared on entry to S_EOC_HI and to S_EOC_LO. Reaching EOC_TIMEOUT aborts the channel: error=1, canale advances as in S_LATCH, no frame sent, next state S_MUX.
- Tx FSM: T_IDLE, T_WAIT_DSR, T_START, T_DATA, T_PAR, T_STOP.
  - Each bit state lasts exactly BIT_CYC cycles.
  - Bit values: START=0; DATA = payload MSB first, DATA_W bits; PAR = XOR of payload (even parity), present only if PARITY_EN; STOP=1.
  - Frame length = (2+DATA_W+PARITY_EN)*BIT_CYC cycles.
- With TAG_EN, the tag frame and the data frame are sent back to back. Each frame re-checks dsr. tx_done pulses only after the data frame.
- DSR: sampled only in T_IDLE/T_WAIT_DSR at frame start.
  - dsr=0 at request: error=1, enter T_WAIT_DSR, hold data_out=1.
  - dsr rising to 1: frame starts the next cycle.
  - dsr dropping mid-frame is ignored.
- error: set by timeout or DSR stall; cleared on the first cycle of T_START of a data frame. A set and a clear in the same cycle resolve to set.
- busy=1 from S_SOC through S_TX inclusive.
- Channel order strictly 0..NUM_CH-1 then wraps; canale never reaches NUM_CH.

Decomposition:
- Shared package adc_scan_pkg: scan-state and tx-state enums and encodings, frame bit-type constants, clog2 helper.
- One natural sub-module: uart_frame_tx (start/payload/parity/stop serializer with BIT_CYC counter, dsr gate, done pulse), instantiated once and reused for tag and data frames.

Test Plan:
1. Defaults, eoc high 3 cycles after soc, data_in=8'hA5, dsr=1 -> line bits 0,1,0,1,0,0,1,0,1,1 each 105 cycles; tx_done pulse; canale 0->1.
2. Run NUM_CH=4 for 5 conversions -> canale sequence 1,2,3,0,1; load_dato exactly 5 single-cycle pulses.
3. PARITY_EN=1, TAG_EN=1, channel 2, data 8'h07 -> tag frame payload 8'h02 parity 1, then data frame parity 1; frame 11*105 cycles each; one tx_done.
4. dsr=0 at request for 300 cycles -> error=1, data_out=1 throughout; dsr=1 -> START next cycle, error clears there.
5. eoc held low after soc -> after 255 cycles error=1, no frame, canale advances, next S_MUX follows.
6. Assert reset mid-DATA bit -> same cycle data_out=1, canale=0, all strobes 0; clean frame after release.
